// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and lane helpers for the LSU data memory.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // LSU operation codes as seen on i_lsu_op
    typedef enum logic [3:0] {
        OP_LB  = 4'b0000,
        OP_LBU = 4'b0001,
        OP_LH  = 4'b0010,
        OP_LHU = 4'b0011,
        OP_LW  = 4'b0100,
        OP_SB  = 4'b1000,
        OP_SH  = 4'b1001,
        OP_SW  = 4'b1010
    } lsu_op_e;

    // Controller states
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        SPLIT = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    // Access size code: 0 byte, 1 half, 2 word
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
            OP_LW, OP_SW:         op_size = 2'd2;
            default:              op_size = 2'd0;
        endcase
    endfunction

    // Byte lanes touched by the access when it starts at offset 0
    function automatic logic [3:0] lane_mask(input logic [3:0] op);
        case (op_size(op))
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // True when the access spills into the next word
    function automatic logic crosses(input logic [3:0] op, input logic [1:0] off);
        case (op_size(op))
            2'd1:    crosses = (off == 2'd3);
            2'd2:    crosses = (off != 2'd0);
            default: crosses = 1'b0;
        endcase
    endfunction

    // Sign/zero extension of an LSB-aligned load value
    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_LB:   load_ext = {{24{d[7]}}, d[7:0]};
            OP_LBU:  load_ext = {24'd0, d[7:0]};
            OP_LH:   load_ext = {{16{d[15]}}, d[15:0]};
            OP_LHU:  load_ext = {16'd0, d[15:0]};
            default: load_ext = d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : LSU request/response bus between core and data memory.
// Revision    : 1.0  initial release
// ============================================================================
interface dmem_if;
    logic        i_req;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_lsu_op;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic        o_busy;

    modport master (
        output i_req, i_addr, i_wdata, i_lsu_op,
        input  o_ready, o_rvalid, o_rdata, o_fault, o_busy
    );

    modport slave (
        input  i_req, i_addr, i_wdata, i_lsu_op,
        output o_ready, o_rvalid, o_rdata, o_fault, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : Word array, combinational read, byte-enabled synchronous write.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_bank #(
    parameter int DEPTH_WORDS = 8192
) (
    input  logic                           i_clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output logic [31:0]                    o_rdata,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [3:0]                     i_wbe,
    input  logic [31:0]                    i_wdata
);
    logic [31:0] mem_q [DEPTH_WORDS];

    assign o_rdata = mem_q[i_raddr];

    // Byte-lane write; lanes with a clear enable keep their contents
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wbe[b]) begin
                    mem_q[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : LSU data memory controller: clear sweep, lane alignment,
//               two-beat word-crossing accesses, registered responses.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 8192,
    parameter int MISALIGN_EN  = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic  i_clk,
    input  logic  i_reset,
    dmem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DEPTH_WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_q, clr_d;
    logic [IDX_W-1:0] idx2_q, idx2_d;
    logic [1:0]       off_q, off_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       hi_be_q, hi_be_d;
    logic [31:0]      hi_data_q, hi_data_d;
    logic [31:0]      hold_q, hold_d;
    logic             rvalid_q, rvalid_d;
    logic             fault_q, fault_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [IDX_W-1:0] w_idx, w_raddr, w_waddr;
    logic [1:0]       w_off;
    logic [3:0]       w_op, w_wbe;
    logic [4:0]       w_shamt;
    logic [63:0]      w_st_wide;
    logic [7:0]       w_st_be;
    logic [31:0]      w_rdata, w_wdata, w_split_rd;
    logic             w_accept, w_legal, w_cross, w_we;
    logic             w_unused_addr;

    assign w_idx         = bus.i_addr[IDX_W+1:2];
    assign w_off         = bus.i_addr[1:0];
    assign w_op          = bus.i_lsu_op;
    assign w_unused_addr = ^bus.i_addr[31:IDX_W+2];
    assign w_shamt       = {w_off, 3'b000};
    assign w_accept      = bus.i_req && (state_q == IDLE);
    assign w_legal       = is_load(w_op) || is_store(w_op);
    assign w_cross       = crosses(w_op, w_off);
    // Store data and enables laid across two consecutive words
    assign w_st_wide     = {32'd0, bus.i_wdata} << w_shamt;
    assign w_st_be       = {4'd0, lane_mask(w_op)} << w_off;
    // Second-beat word above, held first-beat word below, then realign
    assign w_split_rd    = 32'({w_rdata, hold_q} >> {off_q, 3'b000});

    assign bus.o_ready  = (state_q == IDLE);
    assign bus.o_busy   = (state_q == INIT);
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_rdata  = rdata_q;
    assign bus.o_fault  = fault_q;

    // Next state, memory port control and response generation
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        idx2_d    = idx2_q;
        off_d     = off_q;
        op_d      = op_q;
        hi_be_d   = hi_be_q;
        hi_data_d = hi_data_q;
        hold_d    = hold_q;
        rvalid_d  = 1'b0;
        fault_d   = 1'b0;
        rdata_d   = 32'd0;
        w_raddr   = w_idx;
        w_waddr   = w_idx;
        w_we      = 1'b0;
        w_wbe     = 4'd0;
        w_wdata   = w_st_wide[31:0];
        case (state_q)
            INIT: begin
                w_we    = 1'b1;
                w_waddr = clr_q;
                w_wbe   = 4'hF;
                w_wdata = 32'd0;
                clr_d   = clr_q + c_idx_one;
                if (clr_q == c_idx_last) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    if (!w_legal || (w_cross && MISALIGN_EN == 0)) begin
                        rvalid_d = 1'b1;
                        fault_d  = 1'b1;
                    end else if (w_cross) begin
                        state_d   = SPLIT;
                        idx2_d    = w_idx + c_idx_one;
                        off_d     = w_off;
                        op_d      = w_op;
                        hi_be_d   = w_st_be[7:4];
                        hi_data_d = w_st_wide[63:32];
                        hold_d    = w_rdata;
                        w_we      = is_store(w_op);
                        w_wbe     = w_st_be[3:0];
                    end else begin
                        rvalid_d = 1'b1;
                        w_we     = is_store(w_op);
                        w_wbe    = w_st_be[3:0];
                        if (is_load(w_op)) begin
                            rdata_d = load_ext(w_op, w_rdata >> w_shamt);
                        end
                    end
                end
            end
            SPLIT: begin
                w_raddr  = idx2_q;
                w_waddr  = idx2_q;
                w_we     = is_store(op_q);
                w_wbe    = hi_be_q;
                w_wdata  = hi_data_q;
                rvalid_d = 1'b1;
                if (is_load(op_q)) begin
                    rdata_d = load_ext(op_q, w_split_rd);
                end
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset aborts any in-flight access
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= (CLEAR_ON_RST != 0) ? INIT : IDLE;
            clr_q    <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    // Second-beat context; only meaningful while in SPLIT
    always_ff @(posedge i_clk) begin
        idx2_q    <= idx2_d;
        off_q     <= off_d;
        op_q      <= op_d;
        hi_be_q   <= hi_be_d;
        hi_data_q <= hi_data_d;
        hold_q    <= hold_d;
    end

    // Writes are suppressed under reset so a pending second beat is dropped
    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .i_clk   (i_clk),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata),
        .i_we    (w_we && !i_reset),
        .i_waddr (w_waddr),
        .i_wbe   (w_wbe),
        .i_wdata (w_wdata)
    );
endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed vector bench for dmem_ctrl (split and fault configs).
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if bus_a ();
    dmem_if bus_b ();

    dmem_ctrl #(.DEPTH_WORDS(8192), .MISALIGN_EN(1), .CLEAR_ON_RST(1)) u_a (
        .i_clk(clk), .i_reset(rst), .bus(bus_a));
    dmem_ctrl #(.DEPTH_WORDS(16), .MISALIGN_EN(0), .CLEAR_ON_RST(1)) u_b (
        .i_clk(clk), .i_reset(rst), .bus(bus_b));

    typedef struct {
        logic        sel;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_flt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic sel, input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input logic flt,
                                input int lat);
        vec_t v;
        v.sel = sel; v.op = op; v.addr = addr; v.wdata = wd;
        v.exp_rd = rd; v.exp_flt = flt; v.exp_lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic req, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (sel) begin
            bus_b.i_req = req; bus_b.i_lsu_op = op; bus_b.i_addr = addr; bus_b.i_wdata = wd;
        end else begin
            bus_a.i_req = req; bus_a.i_lsu_op = op; bus_a.i_addr = addr; bus_a.i_wdata = wd;
        end
    endtask

    // One request; returns response data, fault, cycles to response, o_ready at N+1
    task automatic xact(input logic sel, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output logic rdy1);
        int   guard;
        logic rv;
        drive(sel, 1'b1, op, addr, wd);
        guard = 0;
        while (!(sel ? bus_b.o_ready : bus_a.o_ready) && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 4'h0, 32'h0, 32'h0);
        rdy1 = sel ? bus_b.o_ready : bus_a.o_ready;
        lat  = 1;
        rv   = sel ? bus_b.o_rvalid : bus_a.o_rvalid;
        while (!rv && lat < 6) begin
            @(posedge clk); #1; lat++;
            rv = sel ? bus_b.o_rvalid : bus_a.o_rvalid;
        end
        if (!rv) lat = -1;
        rd  = sel ? bus_b.o_rdata : bus_a.o_rdata;
        flt = sel ? bus_b.o_fault : bus_a.o_fault;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        flt, rdy1;
        int          lat, cnt_a, cnt_b, rv_seen;

        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

        // Configuration A: 8192 words, crossing accesses split
        add(0, OP_LW,  32'h0000_0000, 32'h0,         32'h0000_0000, 0, 1);
        add(0, OP_LW,  32'h0000_7FFC, 32'h0,         32'h0000_0000, 0, 1);
        add(0, OP_SW,  32'h0000_0100, 32'hDEADBEEF,  32'h0000_0000, 0, 1);
        add(0, OP_LB,  32'h0000_0103, 32'h0,         32'hFFFF_FFDE, 0, 1);
        add(0, OP_LBU, 32'h0000_0101, 32'h0,         32'h0000_00BE, 0, 1);
        add(0, OP_LHU, 32'h0000_0102, 32'h0,         32'h0000_DEAD, 0, 1);
        add(0, OP_LH,  32'h0000_0100, 32'h0,         32'hFFFF_BEEF, 0, 1);
        add(0, OP_LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 1);
        add(0, OP_SH,  32'h0000_0102, 32'hFFFF_1234, 32'h0000_0000, 0, 1);
        add(0, OP_LW,  32'h0000_0100, 32'h0,         32'h1234_BEEF, 0, 1);
        add(0, OP_SB,  32'h0000_0100, 32'hAAAA_AA55, 32'h0000_0000, 0, 1);
        add(0, OP_LW,  32'h0000_0100, 32'h0,         32'h1234_BE55, 0, 1);
        add(0, OP_SW,  32'h0000_01FE, 32'hAABBCCDD,  32'h0000_0000, 0, 2);
        add(0, OP_LW,  32'h0000_01FC, 32'h0,         32'hCCDD_0000, 0, 1);
        add(0, OP_LW,  32'h0000_0200, 32'h0,         32'h0000_AABB, 0, 1);
        add(0, OP_LW,  32'h0000_01FE, 32'h0,         32'hAABB_CCDD, 0, 2);
        add(0, OP_LH,  32'h0000_01FF, 32'h0,         32'hFFFF_BBCC, 0, 2);
        add(0, OP_LHU, 32'h0000_01FF, 32'h0,         32'h0000_BBCC, 0, 2);
        add(0, OP_LH,  32'h0000_01FE, 32'h0,         32'hFFFF_CCDD, 0, 1);
        add(0, 4'b0111,32'h0000_0100, 32'h0,         32'h0000_0000, 1, 1);
        add(0, 4'b1011,32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
        add(0, OP_LW,  32'h0000_0100, 32'h0,         32'h1234_BE55, 0, 1);
        add(0, OP_SW,  32'h0000_7FFE, 32'h11223344,  32'h0000_0000, 0, 2);
        add(0, OP_LW,  32'h0000_7FFE, 32'h0,         32'h1122_3344, 0, 2);
        add(0, OP_LW,  32'h0000_0000, 32'h0,         32'h0000_1122, 0, 1);
        add(0, OP_LW,  32'h0000_7FFC, 32'h0,         32'h3344_0000, 0, 1);
        add(0, OP_LW,  32'hFFFF_0100, 32'h0,         32'h1234_BE55, 0, 1);
        add(0, OP_SW,  32'h0000_0003, 32'h01020304,  32'h0000_0000, 0, 2);
        add(0, OP_LW,  32'h0000_0000, 32'h0,         32'h0400_1122, 0, 1);
        add(0, OP_LW,  32'h0000_0004, 32'h0,         32'h0001_0203, 0, 1);
        add(0, OP_LB,  32'h0000_0003, 32'h0,         32'h0000_0004, 0, 1);
        // Configuration B: 16 words, crossing accesses fault
        add(1, OP_LW,  32'h0000_0000, 32'h0,         32'h0000_0000, 0, 1);
        add(1, OP_SW,  32'h0000_0000, 32'h11223344,  32'h0000_0000, 0, 1);
        add(1, OP_LW,  32'h0000_0001, 32'h0,         32'h0000_0000, 1, 1);
        add(1, OP_SW,  32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
        add(1, OP_LW,  32'h0000_0000, 32'h0,         32'h1122_3344, 0, 1);
        add(1, OP_LH,  32'h0000_0003, 32'h0,         32'h0000_0000, 1, 1);
        add(1, OP_LHU, 32'h0000_0002, 32'h0,         32'h0000_1122, 0, 1);
        add(1, OP_LW,  32'h0000_0004, 32'h0,         32'h0000_0000, 0, 1);
        add(1, OP_LW,  32'h0000_0040, 32'h0,         32'h1122_3344, 0, 1);

        // Reset state and clear-sweep duration
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready",  {31'd0, bus_a.o_ready},  32'd0);
        check("rst_busy",   {31'd0, bus_a.o_busy},   32'd1);
        check("rst_rvalid", {31'd0, bus_a.o_rvalid}, 32'd0);
        check("rst_rdata",  bus_a.o_rdata,           32'd0);
        check("rst_fault",  {31'd0, bus_a.o_fault},  32'd0);
        rst   = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        while (bus_a.o_busy && cnt_a < 10000) begin
            cnt_a++;
            if (bus_b.o_busy) cnt_b++;
            @(posedge clk); #1;
        end
        check("busy_cycles_a", cnt_a, 8192);
        check("busy_cycles_b", cnt_b, 16);
        check("ready_after_init", {31'd0, bus_a.o_ready}, 32'd1);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            xact(vecs[i].sel, vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, flt, lat, rdy1);
            n_vec++;
            if (rd !== vecs[i].exp_rd || flt !== vecs[i].exp_flt || lat != vecs[i].exp_lat) begin
                n_bad++;
                $display("FAIL vec%0d op=%b addr=%h: got rd=%h flt=%b lat=%0d expected rd=%h flt=%b lat=%0d",
                         i, vecs[i].op, vecs[i].addr, rd, flt, lat,
                         vecs[i].exp_rd, vecs[i].exp_flt, vecs[i].exp_lat);
            end
        end

        // Split load holds off new requests for one cycle
        xact(1'b0, OP_LW, 32'h0000_01FE, 32'h0, rd, flt, lat, rdy1);
        check("split_ready_n1", {31'd0, rdy1}, 32'd0);
        check("split_rdata", rd, 32'hAABB_CCDD);

        // Back-to-back: second request accepted while first response is valid
        drive(1'b0, 1'b1, OP_LW, 32'h0000_0100, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, OP_LW, 32'h0000_0200, 32'h0);
        check("b2b_rv_rdy1", {30'd0, bus_a.o_rvalid, bus_a.o_ready}, 32'd3);
        check("b2b_rd1", bus_a.o_rdata, 32'h1234_BE55);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("b2b_rv2", {31'd0, bus_a.o_rvalid}, 32'd1);
        check("b2b_rd2", bus_a.o_rdata, 32'h0000_AABB);
        @(posedge clk); #1;

        // Reset while a split store waits for its second beat
        drive(1'b0, 1'b1, OP_SW, 32'h0000_02FE, 32'h99887766);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("abort_in_split", {31'd0, bus_a.o_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rvalid", {31'd0, bus_a.o_rvalid}, 32'd0);
        check("abort_busy",   {31'd0, bus_a.o_busy},   32'd1);
        check("abort_beat1",  u_a.u_bank.mem_q[191],   32'h7766_0000);
        check("abort_beat2",  u_a.u_bank.mem_q[192],   32'h0000_0000);
        cnt_a   = 0;
        rv_seen = 0;
        while (bus_a.o_busy && cnt_a < 10000) begin
            if (bus_a.o_rvalid) rv_seen++;
            cnt_a++;
            @(posedge clk); #1;
        end
        check("abort_no_resp", rv_seen, 0);
        check("abort_reinit",  cnt_a,   8192);
        xact(1'b0, OP_LW, 32'h0000_02FC, 32'h0, rd, flt, lat, rdy1);
        check("abort_cleared", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
